// File: rtl/eth_pkg.sv
// Shared types and constants for the UDP TX header chain.
// Holds the scheduler state encoding and header/gap defaults.
package eth_pkg;

   typedef enum logic [1:0] {
      IDLE,
      START,
      WAIT_DONE,
      IFG
   } sched_state_t;

   localparam int IP_UDP_HDR_LEN = 28;
   localparam int IFG_DEFAULT    = 12;

endpackage

// File: rtl/udp_tx_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting at ptr.
// Returns the winner both one-hot and as an index.
module rr_arbiter
   import eth_pkg::*;
#(
   parameter  int N = 4,
   localparam int W = $clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [N-1:0] gnt,
   output logic [W-1:0] idx
);

   logic found;

   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (!found && req[(int'(ptr) + i) % N]) begin
            found = 1'b1;
            gnt[(int'(ptr) + i) % N] = 1'b1;
            idx = W'((int'(ptr) + i) % N);
         end
      end
   end

endmodule

// File: rtl/udp_tx_scheduler.sv
// udp_tx_scheduler: round-robin owner of the shared Eth/IP/UDP TX chain.
// Optional WAIT_DONE watchdog enabled by defining UDP_TX_TIMEOUT_EN.
module udp_tx_scheduler
   import eth_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int IFG_CYCLES     = IFG_DEFAULT,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic [NUM_REQ-1:0]    req,
   input  logic [16*NUM_REQ-1:0] req_udp_len,
   input  logic [32*NUM_REQ-1:0] req_ip_d_addr,
   input  logic                  frame_done,
   output logic                  tx_start,
   output logic [15:0]           udp_len,
   output logic [31:0]           ip_d_addr,
   output logic [NUM_REQ-1:0]    grant,
   output logic [NUM_REQ-1:0]    grant_done,
   output logic                  busy,
   output logic                  tx_abort
);

   localparam int IW = $clog2(NUM_REQ);
   localparam int GW = $clog2(IFG_CYCLES + 1);

   if (NUM_REQ < 2 || NUM_REQ > 8 || IFG_CYCLES < 1 ||
       TIMEOUT_CYCLES < 2) begin : g_bad_param
      $error("udp_tx_scheduler: illegal parameter");
   end

   sched_state_t       state, state_nx;
   logic [IW-1:0]      ptr, win_idx;
   logic [NUM_REQ-1:0] win_gnt;
   logic [GW-1:0]      gap_cnt;
   logic               fin, abort, expired;

   rr_arbiter #(.N(NUM_REQ)) u_arb (
      .req (req),
      .ptr (ptr),
      .gnt (win_gnt),
      .idx (win_idx)
   );

`ifdef UDP_TX_TIMEOUT_EN
   localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
   logic [WW-1:0] wd_cnt;

   assign expired = (wd_cnt == WW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         wd_cnt   <= '0;
         tx_abort <= 1'b0;
      end else begin
         wd_cnt   <= (state == WAIT_DONE) ? wd_cnt + 1'b1 : '0;
         tx_abort <= abort;
      end
   end
`else
   assign expired  = 1'b0;
   assign tx_abort = 1'b0;
`endif

   assign tx_start = (state == START);
   assign busy     = (state != IDLE);

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) state <= IDLE;
      else          state <= state_nx;
   end

   // completion beats a watchdog expiry landing on the same cycle
   always_comb begin
      state_nx = state;
      fin      = 1'b0;
      abort    = 1'b0;
      unique case (state)
         IDLE:      if (|req) state_nx = START;
         START:     state_nx = WAIT_DONE;
         WAIT_DONE: begin
            fin   = frame_done;
            abort = !frame_done && expired;
            if (fin || abort) state_nx = IFG;
         end
         IFG:       if (gap_cnt == GW'(IFG_CYCLES - 1)) state_nx = IDLE;
         default:   state_nx = IDLE;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         ptr        <= '0;
         gap_cnt    <= '0;
         udp_len    <= '0;
         ip_d_addr  <= '0;
         grant      <= '0;
         grant_done <= '0;
      end else begin
         grant_done <= '0;
         gap_cnt    <= (state == IFG) ? gap_cnt + 1'b1 : '0;
         if (state == IDLE && |req) begin
            udp_len   <= req_udp_len[16*win_idx +: 16];
            ip_d_addr <= req_ip_d_addr[32*win_idx +: 32];
            grant     <= win_gnt;
            ptr       <= (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
         end
         if (fin || abort) begin
            grant_done <= grant;
            grant      <= '0;
         end
      end
   end

endmodule
